instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit: the initiator that reads the instruction memory. It holds the 64-bit program counter and drives the memory's word address. It captures each returned 32-bit instruction into a small fetch queue and hands instructions to decode over a valid/ready handshake. Branch/jump redirects flush the queue, and a misaligned redirect target stops fetch with a sticky fault.

## Interface
- RESET_PC, default 64'd0: byte address fetched first after reset; must be 4-byte aligned.
- DEPTH, default 2: fetch queue entries; power of two, at least 2.

- CLK, input, 1: single clock; all state updates on its rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- IMEM_ADDR, output, 64: word index into instruction memory, `{2'b00, PC[63:2]}`.
- IMEM_DATA, input, 32: instruction word; combinational from IMEM_ADDR in the same cycle.
- INSTR, output, 32: instruction at the queue head.
- INSTR_PC, output, 64: byte PC of INSTR.
- INSTR_VALID, output, 1: queue head is valid.
- INSTR_READY, input, 1: decode accepts the head this cycle.
- REDIRECT, input, 1: branch/jump taken; flush and refetch.
- REDIRECT_PC, input, 64: new byte PC, sampled when REDIRECT=1.
- FETCH_FAULT, output, 1: sticky; a misaligned redirect was received.

## Operation
- Registers:
  - PC (64 bits).
  - Queue of DEPTH entries, each {instr[31:0], pc[63:0]}.
  - Read/write pointers and an occupancy count (0..DEPTH).
  - Two-state FSM: RUN and FAULT.
- Reset (asynchronous): PC=RESET_PC, count=0, pointers=0, state=RUN. Resulting outputs: INSTR_VALID=0, INSTR=0, INSTR_PC=0, FETCH_FAULT=0, IMEM_ADDR=RESET_PC>>2.
- Pop: when INSTR_VALID && INSTR_READY at a clock edge, the head is consumed.
- Push (RUN, no REDIRECT): occurs when count<DEPTH, or when count==DEPTH and a pop happens the same cycle.
  - Writes {IMEM_DATA, PC} to the queue.
  - Advances PC by 4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - With no push, PC holds.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, the freed slot is refilled in the same edge.
- REDIRECT in RUN has priority over push:
  - A handshake in the same cycle still counts as accepted by decode.
  - All queue entries are discarded (count=0) and nothing is pushed.
  - If REDIRECT_PC[1:0]==0: PC=REDIRECT_PC, stay in RUN.
  - Otherwise: go to FAULT, PC unchanged.
- FAULT state:
  - FETCH_FAULT=1, INSTR_VALID=0.
  - No pushes; REDIRECT is ignored.
  - IMEM_ADDR holds the last PC.
  - The only exit is RESET_N=0.
- INSTR/INSTR_PC show the head entry when INSTR_VALID=1 and hold their last value otherwise. Decode must ignore them when INSTR_VALID=0.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never goes below 0. A pop with an empty queue cannot occur, because INSTR_VALID=0.

## Timing
- Fetch-to-valid latency is 1 cycle: a word pushed at edge t is visible as INSTR_VALID=1 after edge t.
- First instruction after reset release: INSTR_VALID=1 after the first rising edge, with INSTR_PC=RESET_PC.
- Redirect latency:
  - REDIRECT high in cycle t: INSTR_VALID=0 after edge t.
  - Target fetched in cycle t+1; INSTR_VALID=1 with INSTR_PC=target after edge t+1.
- Throughput is 1 instruction/cycle with INSTR_READY held high, including at steady state with the queue full.
- Backpressure: with INSTR_READY=0, the queue fills in DEPTH cycles, then PC stalls. IMEM_ADDR stays on the next unfetched word.
- RESET_N asserted mid-stream clears all state immediately, without waiting for a clock edge. Fetch restarts from RESET_PC on the first edge after release.
- No combinational path from INSTR_READY or REDIRECT to INSTR_VALID. IMEM_ADDR depends only on PC.

## Test plan
- Streaming:
  - Stimulus: memory words 0..5 = A0..A5, RESET_PC=0, INSTR_READY=1.
  - Required: A0..A5 delivered on consecutive cycles with INSTR_PC 0,4,...,20. IMEM_ADDR steps 0,1,...,5.
- Backpressure:
  - Stimulus: INSTR_READY=0 for 5 cycles, then 1.
  - Required: count saturates at 2 and PC holds at 8. After release, A0, A1, A2... follow with no gap and no duplicate.
- Full push+pop:
  - Stimulus: queue full, INSTR_READY pulsed for one cycle.
  - Required: A0 popped, A2 pushed in the same edge; count stays 2; PC goes 8->12.
- Redirect:
  - Stimulus: REDIRECT=1, REDIRECT_PC=16 while INSTR_PC=4 is valid and accepted.
  - Required: 4 is consumed, 8 is never delivered, valid drops one cycle, then 16 (A4) and 20 (A5) follow.
- Fault:
  - Stimulus: REDIRECT_PC=0x...06.
  - Required: FETCH_FAULT=1 and INSTR_VALID=0 permanently; a later aligned REDIRECT is ignored; RESET_N low clears the fault.
- Wrap and reset:
  - Stimulus A: RESET_PC=0xFFFF_FFFF_FFFF_FFFC.
  - Required A: second INSTR_PC=0.
  - Stimulus B: RESET_N pulsed low between edges mid-stream.
  - Required B: INSTR_VALID=0 immediately, then restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the instruction-memory word address from the PC, buffers
// returned words in a small queue for decode, and handles redirects and misaligned-target faults.
//
// state | meaning
// RUN   | fetching; pushes whenever the queue has (or is freeing) a slot
// FAULT | misaligned redirect seen; fetch stopped until reset
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [63:0]     pc, pc_nx;
  logic [PW-1:0]   rptr, wptr, rptr_nx, wptr_nx;
  logic [CW-1:0]   count, count_nx;
  logic [31:0]     q_instr [DEPTH];
  logic [63:0]     q_pc    [DEPTH];

  logic            pop, push, flush, valid_nx;
  logic [31:0]     head_instr;
  logic [63:0]     head_pc;

  assign imem_addr   = {2'b00, pc[63:2]};
  assign fetch_fault = (state == FAULT);

  always_comb begin
    pop      = instr_valid && instr_ready;
    flush    = (state == RUN) && redirect;
    push     = (state == RUN) && !redirect && ((count != FULL) || pop);
    state_nx = state;
    pc_nx    = pc;
    rptr_nx  = pop ? rptr + PW'(1) : rptr;
    wptr_nx  = push ? wptr + PW'(1) : wptr;
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
    if (push) pc_nx = pc + 64'd4;
    if (flush) begin
      rptr_nx  = '0;
      wptr_nx  = '0;
      count_nx = '0;
      if (redirect_pc[1:0] == 2'b00) pc_nx = redirect_pc;
      else                           state_nx = FAULT;
    end
    valid_nx = (count_nx != '0) && (state_nx == RUN);
    // A word pushed into an otherwise-empty slot becomes the head straight away.
    if (push && (wptr == rptr_nx)) begin
      head_instr = imem_data;
      head_pc    = pc;
    end else begin
      head_instr = q_instr[rptr_nx];
      head_pc    = q_pc[rptr_nx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      rptr        <= rptr_nx;
      wptr        <= wptr_nx;
      count       <= count_nx;
      instr_valid <= valid_nx;
      if (valid_nx) begin
        instr    <= head_instr;
        instr_pc <= head_pc;
      end
    end
  end

  // Queue storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wptr] <= imem_data;
      q_pc[wptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for streaming, backpressure, redirect and
// fault, plus hand sequences for mid-stream async reset and PC wrap-around.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  logic        rst_w_n;
  logic [63:0] addr_w;
  logic [31:0] data_w;
  logic [31:0] instr_w;
  logic [63:0] ipc_w;
  logic        valid_w;
  logic        fault_w;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hA000_0000 + a[31:0];
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign data_w    = mem_word(addr_w);

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'd0), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_w (
    .clk(clk), .reset_n(rst_w_n), .imem_addr(addr_w), .imem_data(data_w),
    .instr(instr_w), .instr_pc(ipc_w), .instr_valid(valid_w), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(64'd0), .fetch_fault(fault_w)
  );

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rdr;
    logic [63:0] rpc;
    bit          ev;
    logic [63:0] epc;
    logic [63:0] eaddr;
    bit          ef;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t v(input bit rst, input bit rdy, input bit rdr, input logic [63:0] rpc,
                             input bit ev, input logic [63:0] epc, input logic [63:0] eaddr,
                             input bit ef);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.rdr = rdr; t.rpc = rpc;
    t.ev = ev; t.epc = epc; t.eaddr = eaddr; t.ef = ef;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    // streaming from reset
    tbl[0]  = v(0, 1, 0, 0,       1, 0,  1, 0);
    tbl[1]  = v(0, 1, 0, 0,       1, 4,  2, 0);
    tbl[2]  = v(0, 1, 0, 0,       1, 8,  3, 0);
    tbl[3]  = v(0, 1, 0, 0,       1, 12, 4, 0);
    tbl[4]  = v(0, 1, 0, 0,       1, 16, 5, 0);
    tbl[5]  = v(0, 1, 0, 0,       1, 20, 6, 0);
    // backpressure, then single-cycle ready on a full queue
    tbl[6]  = v(1, 0, 0, 0,       1, 0,  1, 0);
    tbl[7]  = v(0, 0, 0, 0,       1, 0,  2, 0);
    tbl[8]  = v(0, 0, 0, 0,       1, 0,  2, 0);
    tbl[9]  = v(0, 0, 0, 0,       1, 0,  2, 0);
    tbl[10] = v(0, 0, 0, 0,       1, 0,  2, 0);
    tbl[11] = v(0, 1, 0, 0,       1, 4,  3, 0);
    tbl[12] = v(0, 0, 0, 0,       1, 4,  3, 0);
    tbl[13] = v(0, 1, 0, 0,       1, 8,  4, 0);
    tbl[14] = v(0, 1, 0, 0,       1, 12, 5, 0);
    tbl[15] = v(0, 1, 0, 0,       1, 16, 6, 0);
    // redirect to 16 while 4 is accepted
    tbl[16] = v(1, 1, 0, 0,       1, 0,  1, 0);
    tbl[17] = v(0, 1, 0, 0,       1, 4,  2, 0);
    tbl[18] = v(0, 1, 1, 64'd16,  0, 4,  4, 0);
    tbl[19] = v(0, 1, 0, 0,       1, 16, 5, 0);
    tbl[20] = v(0, 1, 0, 0,       1, 20, 6, 0);
    // misaligned redirect, later aligned redirect ignored, reset clears
    tbl[21] = v(0, 1, 1, 64'h6,   0, 20, 6, 1);
    tbl[22] = v(0, 1, 1, 64'h40,  0, 20, 6, 1);
    tbl[23] = v(0, 1, 0, 0,       0, 20, 6, 1);
    tbl[24] = v(1, 1, 0, 0,       1, 0,  1, 0);

    reset_n = 1'b0; rst_w_n = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    step(); step();
    chk("rst valid", {63'd0, instr_valid}, 64'd0);
    chk("rst instr", {32'd0, instr}, 64'd0);
    chk("rst instr_pc", instr_pc, 64'd0);
    chk("rst fault", {63'd0, fetch_fault}, 64'd0);
    chk("rst imem_addr", imem_addr, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (tbl[i].rst) pulse_reset();
      instr_ready = tbl[i].rdy;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("v%0d valid", i), {63'd0, instr_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("v%0d instr_pc", i), instr_pc, tbl[i].epc);
      chk($sformatf("v%0d instr", i), {32'd0, instr}, {32'd0, mem_word(tbl[i].epc >> 2)});
      chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("v%0d fault", i), {63'd0, fetch_fault}, {63'd0, tbl[i].ef});
    end

    // mid-stream asynchronous reset
    instr_ready = 1'b1; redirect = 1'b0;
    step(); step();
    chk("mid valid", {63'd0, instr_valid}, 64'd1);
    chk("mid instr_pc", instr_pc, 64'd8);
    reset_n = 1'b0;
    #1;
    chk("async valid", {63'd0, instr_valid}, 64'd0);
    chk("async instr_pc", instr_pc, 64'd0);
    chk("async instr", {32'd0, instr}, 64'd0);
    chk("async imem_addr", imem_addr, 64'd0);
    #1;
    reset_n = 1'b1;
    step();
    chk("restart valid", {63'd0, instr_valid}, 64'd1);
    chk("restart instr_pc", instr_pc, 64'd0);
    chk("restart instr", {32'd0, instr}, {32'd0, mem_word(64'd0)});

    // PC wrap from the top of the address space
    chk("wrap rst addr", addr_w, 64'h3FFF_FFFF_FFFF_FFFF);
    rst_w_n = 1'b1;
    step();
    chk("wrap first valid", {63'd0, valid_w}, 64'd1);
    chk("wrap first pc", ipc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap first instr", {32'd0, instr_w}, {32'd0, mem_word(64'h3FFF_FFFF_FFFF_FFFF)});
    step();
    chk("wrap second pc", ipc_w, 64'd0);
    chk("wrap second instr", {32'd0, instr_w}, {32'd0, mem_word(64'd0)});
    chk("wrap addr", addr_w, 64'd1);
    chk("wrap fault", {63'd0, fault_w}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
